// File: rtl/counter_pkg.sv
// Shared types and default sizes for the bounded up/down counter family.
// The CNT_SATURATE_EN macro (used in counter_next_calc) selects saturate vs wrap on a limit crossing.
package counter_pkg;

    localparam int CNT_WIDTH_DEF  = 8;
    localparam int CNT_STEP_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } cnt_op_e;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and limit-crossing detection for one count step.
// CNT_SATURATE_EN defined: pin at the crossed bound; undefined: wrap to the opposite bound.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH_DEF,
    parameter int STEP_W = CNT_STEP_W_DEF
) (
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              up_i,
    input  logic [WIDTH-1:0]  limit_lo_i,
    input  logic [WIDTH-1:0]  limit_hi_i,
    output logic [WIDTH-1:0]  nxt_o,
    output logic              cross_o
);

    logic [WIDTH:0] step_x;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit keeps the carry/borrow visible so nothing wraps silently.
    assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign sum    = {1'b0, cnt_i} + step_x;
    assign diff   = {1'b0, cnt_i} - step_x;

    always_comb begin
        nxt_o   = cnt_i;
        cross_o = 1'b0;
        if (up_i) begin
            cross_o = (sum > {1'b0, limit_hi_i});
`ifdef CNT_SATURATE_EN
            nxt_o   = cross_o ? limit_hi_i : sum[WIDTH-1:0];
`else
            nxt_o   = cross_o ? limit_lo_i : sum[WIDTH-1:0];
`endif
        end else begin
            cross_o = diff[WIDTH] || (diff[WIDTH-1:0] < limit_lo_i);
`ifdef CNT_SATURATE_EN
            nxt_o   = cross_o ? limit_lo_i : diff[WIDTH-1:0];
`else
            nxt_o   = cross_o ? limit_hi_i : diff[WIDTH-1:0];
`endif
        end
    end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised bounded up/down counter with load, step, terminal-count pulse and sticky overflow.
// Crossing behaviour (saturate vs wrap) is selected by CNT_SATURATE_EN inside counter_next_calc.
module updn_counter_param
    import counter_pkg::*;
#(
    parameter int               WIDTH     = CNT_WIDTH_DEF,
    parameter int               STEP_W    = CNT_STEP_W_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              ld_cnt_,
    input  logic              count_enb,
    input  logic              updn_cnt,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              ovf_sticky
);

    cnt_op_e          op;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] calc_nxt;
    logic             calc_cross;

    // Zero step or an inverted range makes an enabled count a plain hold.
    always_comb begin
        op = OP_HOLD;
        if (!ld_cnt_) begin
            op = OP_LOAD;
        end else if (count_enb && (step != '0) && (limit_hi >= limit_lo)) begin
            op = updn_cnt ? OP_UP : OP_DOWN;
        end
    end

    counter_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .cnt_i      (cnt_q),
        .step_i     (step),
        .up_i       (op == OP_UP),
        .limit_lo_i (limit_lo),
        .limit_hi_i (limit_hi),
        .nxt_o      (calc_nxt),
        .cross_o    (calc_cross)
    );

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        case (op)
            OP_LOAD: cnt_d = data_in;
            OP_UP, OP_DOWN: begin
                cnt_d = calc_nxt;
                tc_d  = calc_cross;
            end
            default: ;
        endcase
        ovf_d = tc_d ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= RESET_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign data_out   = cnt_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: doc/updn_counter_param.md
# updn_counter_param

Parametrised up/down counter with synchronous load, hold, programmable step and programmable upper/lower limits. It is the general-purpose successor of the fixed 8-bit load/up/down counter, adding width/step generalisation, bounded counting range, terminal-count pulse and sticky overflow. It sits in the datapath wherever a bounded event, address or credit count is needed, and it is checked by a companion property module.

## Interface
- WIDTH, 8, counter, data and limit width (>=2)
- STEP_W, 4, width of the step input (1..WIDTH)
- RESET_VAL, 0, data_out value during and after reset (WIDTH bits)
- clk  in  1  single clock, rising edge
- rst_  in  1  reset, asynchronous, active-low
- ld_cnt_  in  1  synchronous load, active-low
- count_enb  in  1  count enable, active-high
- updn_cnt  in  1  direction: 1 = up, 0 = down
- step  in  STEP_W  unsigned increment/decrement amount
- data_in  in  WIDTH  load value
- limit_lo  in  WIDTH  lower bound, inclusive, unsigned
- limit_hi  in  WIDTH  upper bound, inclusive, unsigned
- clr_ovf  in  1  clears ovf_sticky
- data_out  out  WIDTH  registered count
- tc  out  1  registered one-cycle terminal-count pulse
- ovf_sticky  out  1  registered sticky limit-crossing flag

## Operation
- Priority per cycle: reset > load (ld_cnt_==0) > count (count_enb==1) > hold.
- Load: data_out <= data_in unmodified, even outside [limit_lo, limit_hi]. tc <= 0.
- Hold: data_out unchanged, tc <= 0.
- Count up: sum = data_out + step in WIDTH+1 bits. If sum > limit_hi, a crossing occurs; otherwise data_out <= sum.
- Count down: diff = data_out - step in WIDTH+1 bits, borrow-aware. If the result is negative or below limit_lo, a crossing occurs; otherwise data_out <= diff.
- Crossing: the bound is applied as set by Configuration; tc <= 1; ovf_sticky <= 1.
- Landing exactly on limit_hi or limit_lo is not a crossing.
- step==0 with count_enb: hold, no crossing.
- limit_hi < limit_lo: counting is suppressed (hold, no tc or ovf). Load still works.
- ovf_sticky: cleared by clr_ovf. A set from a crossing in the same cycle wins over clr_ovf.
- No internal wrap of WIDTH bits is possible; all overflow is handled through the limit logic.

## Timing
- Reset (rst_==0, asynchronous): data_out=RESET_VAL, tc=0, ovf_sticky=0. All outputs are held until the first rising clk after rst_ deasserts.
- Load/count latency: 1 cycle. Inputs are sampled at edge N; the result is visible after edge N.
- tc is high for exactly the one cycle following a crossing edge. Back-to-back crossings give tc high on consecutive cycles.
- Reset asserted mid-count forces reset values immediately, with no clock needed.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro CNT_SATURATE_EN.
- Defined: on a crossing up, data_out <= limit_hi; on a crossing down, data_out <= limit_lo. The counter is pinned at the bound, and further counting in the same direction pulses tc every enabled cycle.
- Undefined (default): wrap mode. On a crossing up, data_out <= limit_lo; on a crossing down, data_out <= limit_hi.

## Structure
- Package counter_pkg:
  - typedef enum cnt_op_e {OP_HOLD, OP_LOAD, OP_UP, OP_DOWN}
  - default parameter constants CNT_WIDTH_DEF=8, CNT_STEP_W_DEF=4
- Sub-module counter_next_calc: combinational. Inputs: data_out, step, direction and limits. Outputs: next value and crossing flag. Wrap/saturate selection lives here under CNT_SATURATE_EN.
- Top module: op decode, registers, tc/ovf logic.

## Test plan
- Reset: rst_=0 mid-count with RESET_VAL=8'h05 -> data_out=5, tc=0 and ovf_sticky=0 immediately; they remain so for 1 cycle after rst_ rises.
- Load priority: ld_cnt_=0, count_enb=1, data_in=8'h80 -> data_out=8'h80 next cycle, tc=0.
- Up wrap, macro off: lo=10, hi=200, data_out=196, step=4, up -> 200, tc=0. Next enabled cycle -> 10, tc=1, ovf_sticky=1.
- Down saturate, macro on: lo=10, hi=200, data_out=12, step=5, down -> 10, tc=1. Next cycle again 10, tc=1.
- Full-range up, WIDTH=8: lo=0, hi=255, data_out=254, step=3 -> macro off gives 0, macro on gives 255; tc=1 in both cases.
- Misc: clr_ovf with a simultaneous crossing -> ovf_sticky stays 1. step=0 with count_enb=1 -> hold, tc=0. limit_hi=5, limit_lo=9 -> hold.
